// File: rtl/fwd_stall_unit.sv
// fwd_stall_unit: forwarding and load-use stall controller for the in-order
// RV32I pipeline. It decodes the instruction in ID. It keeps a shift-register
// scoreboard of the DEPTH producers ahead of that instruction. From these it
// derives a combinational load-use stall and registered EX operand selects.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   id_valid        id_inst holds a real instruction
//   id_inst         instruction in ID
//   hold_in         global freeze: state holds, stall still evaluated
//   flush           kill the ID instruction (beats stall)
//   stall           load-use stall to fetch/decode registers (combinational)
//   fwd_rs1_sel     EX operand-1 source: 0=regfile, k=pipeline register k
//   fwd_rs2_sel     EX operand-2 source, same encoding
//   stall_count     saturating count of stall cycles

// Per-source youngest-match search over the scoreboard.
module fwd_match #(
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  logic [4:0]             src_i,
  input  logic                   uses_i,
  input  logic [DEPTH:1]         vld_i,
  input  logic [DEPTH:1][4:0]    rd_i,
  input  logic [DEPTH:1]         ld_i,
  output logic [SEL_W-1:0]       sel_o,
  output logic                   ld_o
);
  always_comb begin
    sel_o = '0;
    ld_o  = 1'b0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int k = DEPTH; k >= 1; k--) begin
      if (uses_i && src_i != 5'd0 && vld_i[k] && rd_i[k] == src_i) begin
        sel_o = SEL_W'(k);
        ld_o  = ld_i[k];
      end
    end
  end
endmodule

module fwd_stall_unit #(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             hold_in,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_rs1_sel,
  output logic [SEL_W-1:0] fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_count
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL = 7'b1101111, OP_JALR  = 7'b1100111,
                         OP_BR  = 7'b1100011, OP_LOAD  = 7'b0000011,
                         OP_ST  = 7'b0100011, OP_IMM   = 7'b0010011,
                         OP_OP  = 7'b0110011;

  // ---------------- decode ----------------
  logic [6:0] opc;
  logic [4:0] rd;
  logic       uses_rs1, uses_rs2, writes_rd, is_load;
  logic       unused_ok;

  assign opc       = id_inst[6:0];
  assign rd        = id_inst[11:7];
  assign unused_ok = ^{id_inst[31:25], id_inst[14:12]};

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
      OP_JALR, OP_LOAD, OP_IMM: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_BR, OP_ST:             begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_OP: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      default: ;
    endcase
    if (rd == 5'd0) writes_rd = 1'b0;
  end
  assign is_load = (opc == OP_LOAD);

  // ---------------- scoreboard ----------------
  // Entry valid already implies "writes a non-zero rd".
  logic [DEPTH:1]      sb_vld_q;
  logic [DEPTH:1][4:0] sb_rd_q;
  logic [DEPTH:1]      sb_ld_q;

  logic [1:0][4:0]       src;
  logic [1:0]            uses;
  logic [1:0][SEL_W-1:0] win;
  logic [1:0]            win_ld;
  logic [1:0]            src_stall;

  assign src  = {id_inst[24:20], id_inst[19:15]};
  assign uses = {uses_rs2, uses_rs1};

  for (genvar s = 0; s < 2; s++) begin : g_src
    fwd_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match (
      .src_i (src[s]),
      .uses_i(uses[s]),
      .vld_i (sb_vld_q),
      .rd_i  (sb_rd_q),
      .ld_i  (sb_ld_q),
      .sel_o (win[s]),
      .ld_o  (win_ld[s])
    );
    // Load data is not yet available in registers younger than LOAD_STAGE.
    assign src_stall[s] = win_ld[s] && (win[s] < SEL_W'(LOAD_STAGE));
  end

  assign stall = id_valid && !flush && (|src_stall);

  // ---------------- state update ----------------
  logic             adv;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel1_q, sel2_q;

  assign adv   = id_valid && !stall && !flush;
  assign cnt_d = (stall && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_vld_q <= '0;
      sb_rd_q  <= '0;
      sb_ld_q  <= '0;
      sel1_q   <= '0;
      sel2_q   <= '0;
      cnt_q    <= '0;
    end else if (!hold_in) begin
      sb_vld_q <= {sb_vld_q[DEPTH-1:1], adv && writes_rd};
      sb_rd_q  <= {sb_rd_q[DEPTH-1:1], rd};
      sb_ld_q  <= {sb_ld_q[DEPTH-1:1], is_load};
      sel1_q   <= adv ? win[0] : '0;
      sel2_q   <= adv ? win[1] : '0;
      cnt_q    <= cnt_d;
    end
  end

  assign fwd_rs1_sel = sel1_q;
  assign fwd_rs2_sel = sel2_q;
  assign stall_count = cnt_q;
endmodule

// File: tb/tb_fwd_stall_unit.sv
module tb_fwd_stall_unit;
  localparam int DEPTH = 3, LS = 2, CNT_W = 4, SEL_W = 2;

  logic clk = 0, rst, id_valid, hold_in, flush, stall;
  logic [31:0] id_inst;
  logic [SEL_W-1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic [CNT_W-1:0] stall_count;

  fwd_stall_unit #(.DEPTH(DEPTH), .LOAD_STAGE(LS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
    .hold_in(hold_in), .flush(flush), .stall(stall),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall_count(stall_count));

  always #5 clk = ~clk;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
    JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011,
    IMM = 7'b0010011, OP = 7'b0110011, SYS = 7'b1110011, FEN = 7'b0001111;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: list of the instructions issued ahead of ID, youngest first.
  typedef struct { bit wr; int rd; bit ld; } ent_t;
  ent_t hist[$];
  int m_sel1, m_sel2, m_cnt;
  logic [31:0] o_s1, o_s2, o_stall;

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd_, input int r1, input int r2);
    return {7'd0, 5'(r2), 5'(r1), 3'd0, 5'(rd_), op};
  endfunction

  task automatic m_reset();
    ent_t b;
    b = '{0, 0, 0};
    hist.delete();
    repeat (DEPTH) hist.push_back(b);
    m_sel1 = 0; m_sel2 = 0; m_cnt = 0;
  endtask

  // Position (1-based) of the youngest earlier writer of src, 0 if none.
  task automatic find(input int src, input bit use_, output int k, output bit ld);
    k = 0; ld = 0;
    if (use_ && src != 0)
      for (int i = 0; i < hist.size(); i++)
        if (hist[i].wr && hist[i].rd == src) begin k = i + 1; ld = hist[i].ld; break; end
  endtask

  task automatic step(input bit v, input logic [31:0] inst, input bit hd, input bit fl, input bit rn);
    int op, rd_, k1, k2;
    bit u1, u2, wr, ld1, ld2, es;
    ent_t e;
    @(negedge clk);
    chk("sel1", 32'(fwd_rs1_sel), m_sel1);
    chk("sel2", 32'(fwd_rs2_sel), m_sel2);
    chk("count", 32'(stall_count), m_cnt);
    o_s1 = 32'(fwd_rs1_sel); o_s2 = 32'(fwd_rs2_sel);
    id_valid = v; id_inst = inst; hold_in = hd; flush = fl; rst = rn;
    #1;
    op = int'(inst[6:0]); rd_ = int'(inst[11:7]);
    u1 = op inside {JALR, BR, LD, ST, IMM, OP};
    u2 = op inside {BR, ST, OP};
    wr = (op inside {LUI, AUIPC, JAL, JALR, LD, IMM, OP}) && rd_ != 0;
    find(int'(inst[19:15]), u1, k1, ld1);
    find(int'(inst[24:20]), u2, k2, ld2);
    es = v && !fl && ((k1 != 0 && ld1 && k1 < LS) || (k2 != 0 && ld2 && k2 < LS));
    chk("stall", 32'(stall), 32'(es));
    o_stall = 32'(stall);
    if (!rn) m_reset();
    else if (!hd) begin
      if (v && !es && !fl) e = '{wr, rd_, op == LD}; else e = '{0, 0, 0};
      hist.push_front(e);
      void'(hist.pop_back());
      m_sel1 = (v && !es && !fl) ? k1 : 0;
      m_sel2 = (v && !es && !fl) ? k2 : 0;
      if (es && m_cnt != (1 << CNT_W) - 1) m_cnt++;
    end
  endtask

  logic [31:0] NOP;
  logic [6:0] ops [11];

  initial begin
    NOP = mk(IMM, 0, 0, 0);
    ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, IMM, OP, SYS, FEN};
    rst = 0; id_valid = 0; id_inst = NOP; hold_in = 0; flush = 0;
    repeat (2) @(posedge clk);
    m_reset();
    step(0, NOP, 0, 0, 1);                       // reset state checked here

    // back-to-back ALU forward
    step(1, mk(OP, 5, 1, 2), 0, 0, 1);
    step(1, mk(OP, 6, 5, 1), 0, 0, 1);
    chk("alu_nostall", o_stall, 0);
    step(1, NOP, 0, 0, 1);
    chk("alu_s1", o_s1, 1); chk("alu_s2", o_s2, 0);

    // load-use: one stall, then forward from register 2
    step(1, mk(LD, 5, 1, 0), 0, 0, 1);
    step(1, mk(OP, 7, 5, 5), 0, 0, 1);
    chk("lu_stall", o_stall, 1);
    step(1, mk(OP, 7, 5, 5), 0, 0, 1);
    chk("lu_stall_once", o_stall, 0);
    step(1, NOP, 0, 0, 1);
    chk("lu_s1", o_s1, 2); chk("lu_s2", o_s2, 2);
    chk("lu_count", 32'(stall_count), 1);

    // distance 3 forwards, distance 4 does not
    step(1, mk(OP, 5, 1, 2), 0, 0, 1);
    step(1, NOP, 0, 0, 1); step(1, NOP, 0, 0, 1);
    step(1, mk(OP, 9, 5, 3), 0, 0, 1);
    step(1, NOP, 0, 0, 1);
    chk("dist3_s1", o_s1, 3);
    step(1, mk(OP, 5, 1, 2), 0, 0, 1);
    repeat (3) step(1, NOP, 0, 0, 1);
    step(1, mk(OP, 9, 5, 3), 0, 0, 1);
    step(1, NOP, 0, 0, 1);
    chk("dist4_s1", o_s1, 0);

    // store data forward; youngest writer wins
    step(1, mk(OP, 5, 1, 2), 0, 0, 1);
    step(1, mk(ST, 0, 6, 5), 0, 0, 1);
    step(1, NOP, 0, 0, 1);
    chk("st_s1", o_s1, 0); chk("st_s2", o_s2, 1);
    step(1, mk(OP, 5, 1, 2), 0, 0, 1);
    step(1, mk(IMM, 5, 5, 0), 0, 0, 1);
    step(1, mk(OP, 8, 5, 0), 0, 0, 1);
    step(1, NOP, 0, 0, 1);
    chk("young_s1", o_s1, 1);

    // flush beats stall
    step(1, mk(LD, 5, 1, 0), 0, 0, 1);
    step(1, mk(OP, 7, 5, 5), 0, 1, 1);
    chk("flush_stall", o_stall, 0);
    step(1, NOP, 0, 0, 1);
    chk("flush_s1", o_s1, 0);

    // reset forgets an in-flight load
    step(1, mk(LD, 5, 1, 0), 0, 0, 1);
    step(1, NOP, 0, 0, 0);
    step(1, mk(OP, 7, 5, 5), 0, 0, 1);
    chk("rst_nostall", o_stall, 0);

    // randomized traffic, small register set for dense hazards
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 10)];
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      step($urandom_range(0, 99) < 85, ins, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) >= 1);
    end
    step(0, NOP, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
